wb_bus_controller: RTL and testbench
====================================

// Module: wb_bus_controller
// PURPOSE
//  Two-master Wishbone-style bus controller for the SoC. Arbitrates between CPU (M0) and
//  a second master (M1, e.g. loader/DMA), decodes address to LED/SEG/VGA/RAM slaves.
//  Sequences each transfer: drives one slave strobe, waits for slave ACK or timeout,
//  then returns one-cycle ACK/ERR and read data to the owning master.
// PARAMETERS
//  LED_ADDR  32'hFFFF0000  exact-match address of LED slave (slave 0)
//  SEG_ADDR  32'hEEEE0000  exact-match address of 7-seg slave (slave 1)
//  VGA_BASE  16'hAAAA      ADR[31:16] match selects VGA slave (slave 2); else RAM (slave 3)
//  TIMEOUT   8'd16         cycles in BUS without slave ACK before ERR (legal 1..255)
// PORTS
//  CLK_I      in   1    system clock
//  RST_I      in   1    synchronous reset, active high
//  M0_CYC_I   in   1    M0 bus cycle valid (drop = abort)
//  M0_STB_I   in   1    M0 transfer request
//  M0_WE_I    in   1    M0 write enable
//  M0_ADR_I   in   32   M0 address
//  M0_DAT_I   in   32   M0 write data
//  M0_DAT_O   out  32   M0 read data, valid when M0_ACK_O
//  M0_ACK_O   out  1    M0 transfer done (1 cycle)
//  M0_ERR_O   out  1    M0 transfer timed out (1 cycle)
//  M1_*       --   --   identical set for master 1
//  S_ADR_O    out  32   address to slaves (latched)
//  S_DAT_O    out  32   write data to slaves (latched)
//  S_WE_O     out  1    write enable to slaves (latched)
//  S_STB_O    out  4    one-hot slave strobe {RAM,VGA,SEG,LED}
//  S_DAT_I    in   128  slave read data, slave n at [32n+31:32n]
//  S_ACK_I    in   4    per-slave acknowledge
//  BUSY_O     out  1    high whenever state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all outputs 0, counter 0, last_grant=M1.
//  - Request from Mx = Mx_CYC_I & Mx_STB_I.
//  - FSM IDLE -> BUS -> RESP -> IDLE.
//  - IDLE: if any request, grant (both request: master != last_grant; else the requester).
//    Latch ADR/DAT/WE, one-hot slave select, last_grant; -> BUS.
//  - BUS: S_STB_O = latched select; counter increments each BUS cycle.
//    Selected S_ACK_I=1 -> capture S_DAT_I slice (zero on write); drop S_STB_O; -> RESP.
//    Counter reaches TIMEOUT with no ACK -> ERR pending, read data 0; drop S_STB_O; -> RESP.
//    Granted master drops CYC -> abort: drop S_STB_O, no ACK/ERR; -> IDLE.
//    ACK and CYC drop same cycle: abort wins. ACK on unselected slave ignored.
//  - RESP: exactly one of Mx_ACK_O/Mx_ERR_O high for one cycle, granted master only;
//    Mx_DAT_O valid this cycle, held until next RESP. -> IDLE. Counter cleared.
//  - Latency: request at IDLE cycle N; S_STB_O at N+1; slave ACK at cycle K>=N+1 gives
//    Mx_ACK_O at K+1. Min 2 cycles request-to-ACK; one transfer per 3 cycles max.
//  - Masters must drop STB in the cycle after ACK/ERR; a still-high STB in IDLE is a new request.
//  - Decode priority: LED_ADDR, SEG_ADDR, VGA_BASE, then RAM default.
//  - Requests arriving in BUS/RESP are not granted until IDLE. Ungranted master waits, no ACK.
//  - Reset mid-transfer: immediate return to reset state, no ACK/ERR, S_STB_O=0 next cycle.
// TESTING
//  - M0 read 0x00000010, RAM ACKs 1st STB cycle w/ 0x12345678 -> S_STB_O=4'b1000 at N+1,
//    M0_ACK_O at N+2, M0_DAT_O=0x12345678.
//  - M0 write 0xFFFF0000 data 0x0000A5A5 -> S_STB_O=4'b0001, S_WE_O=1, S_DAT_O=0x0000A5A5;
//    0xEEEE0000 -> 4'b0010; 0xAAAA1234 -> 4'b0100.
//  - M0,M1 request same cycle after reset, both held -> M0 first, then M1, then M0 alternating.
//  - VGA never ACKs, TIMEOUT=16 -> S_STB_O high 16 cycles, M0_ERR_O=1 1 cycle, M0_DAT_O=0.
//  - M1 drops CYC in 3rd BUS cycle -> S_STB_O=0 next cycle, no M1_ACK_O/M1_ERR_O, BUSY_O=0.
//  - RST_I pulsed during BUS -> all outputs 0 next cycle; next M0 request granted normally.

Source files
------------

// File: rtl/wb_bus_controller.sv
// Two-master Wishbone-style bus controller: arbitrates M0/M1, decodes to LED/SEG/VGA/RAM,
// sequences one strobed transfer at a time and returns a one-cycle ACK/ERR to the owner.
module wb_bus_controller #(
  parameter logic [31:0] LED_ADDR = 32'hFFFF0000,
  parameter logic [31:0] SEG_ADDR = 32'hEEEE0000,
  parameter logic [15:0] VGA_BASE = 16'hAAAA,
  parameter logic [7:0]  TIMEOUT  = 8'd16
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  input  logic         M0_CYC_I,
  input  logic         M0_STB_I,
  input  logic         M0_WE_I,
  input  logic [31:0]  M0_ADR_I,
  input  logic [31:0]  M0_DAT_I,
  output logic [31:0]  M0_DAT_O,
  output logic         M0_ACK_O,
  output logic         M0_ERR_O,
  input  logic         M1_CYC_I,
  input  logic         M1_STB_I,
  input  logic         M1_WE_I,
  input  logic [31:0]  M1_ADR_I,
  input  logic [31:0]  M1_DAT_I,
  output logic [31:0]  M1_DAT_O,
  output logic         M1_ACK_O,
  output logic         M1_ERR_O,
  output logic [31:0]  S_ADR_O,
  output logic [31:0]  S_DAT_O,
  output logic         S_WE_O,
  output logic [3:0]   S_STB_O,
  input  logic [127:0] S_DAT_I,
  input  logic [3:0]   S_ACK_I,
  output logic         BUSY_O
);

  // state    | meaning
  // ST_IDLE  | waiting for a request, arbitrates and latches the transfer
  // ST_BUS   | slave strobe asserted, waiting for ACK, timeout or abort
  // ST_RESP  | one-cycle ACK/ERR to the granted master
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        we_q, we_d;
  logic [3:0]  stb_q, stb_d;
  logic [31:0] m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;
  logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic        busy_q, busy_d;

  logic        req0, req1, owner_cyc, slave_ack;
  logic        resp_fire, resp_ok;
  logic [31:0] slave_rdata, resp_dat;

  assign req0 = M0_CYC_I & M0_STB_I;
  assign req1 = M1_CYC_I & M1_STB_I;
  assign owner_cyc = grant_q ? M1_CYC_I : M0_CYC_I;
  // stb_q equals the latched one-hot select for the whole BUS state
  assign slave_ack = |(stb_q & S_ACK_I);

  function automatic logic [3:0] decode(input logic [31:0] adr);
    if (adr == LED_ADDR)            return 4'b0001;
    else if (adr == SEG_ADDR)       return 4'b0010;
    else if (adr[31:16] == VGA_BASE) return 4'b0100;
    else                            return 4'b1000;
  endfunction

  always_comb begin
    slave_rdata = '0;
    for (int n = 0; n < 4; n++) begin
      if (stb_q[n]) slave_rdata = slave_rdata | S_DAT_I[32*n +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    we_d         = we_q;
    stb_d        = stb_q;
    resp_fire    = 1'b0;
    resp_ok      = 1'b0;
    resp_dat     = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0 | req1) begin
          grant_d      = (req0 & req1) ? ~last_grant_q : req1;
          last_grant_d = grant_d;
          adr_d        = grant_d ? M1_ADR_I : M0_ADR_I;
          wdat_d       = grant_d ? M1_DAT_I : M0_DAT_I;
          we_d         = grant_d ? M1_WE_I : M0_WE_I;
          stb_d        = decode(adr_d);
          state_d      = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + 8'd1;
        // abort outranks a same-cycle ACK and the timeout
        if (!owner_cyc) begin
          stb_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (slave_ack) begin
          stb_d     = '0;
          resp_fire = 1'b1;
          resp_ok   = 1'b1;
          resp_dat  = we_q ? 32'h0 : slave_rdata;
          state_d   = ST_RESP;
        end else if (cnt_d == TIMEOUT) begin
          stb_d     = '0;
          resp_fire = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        stb_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    m0_ack_d = 1'b0;
    m0_err_d = 1'b0;
    m1_ack_d = 1'b0;
    m1_err_d = 1'b0;
    if (resp_fire) begin
      if (grant_q) begin
        m1_dat_d = resp_dat;
        m1_ack_d = resp_ok;
        m1_err_d = ~resp_ok;
      end else begin
        m0_dat_d = resp_dat;
        m0_ack_d = resp_ok;
        m0_err_d = ~resp_ok;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      we_q         <= 1'b0;
      stb_q        <= '0;
      m0_dat_q     <= '0;
      m1_dat_q     <= '0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      we_q         <= we_d;
      stb_q        <= stb_d;
      m0_dat_q     <= m0_dat_d;
      m1_dat_q     <= m1_dat_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      busy_q       <= busy_d;
    end
  end

  assign S_ADR_O  = adr_q;
  assign S_DAT_O  = wdat_q;
  assign S_WE_O   = we_q;
  assign S_STB_O  = stb_q;
  assign M0_DAT_O = m0_dat_q;
  assign M0_ACK_O = m0_ack_q;
  assign M0_ERR_O = m0_err_q;
  assign M1_DAT_O = m1_dat_q;
  assign M1_ACK_O = m1_ack_q;
  assign M1_ERR_O = m1_err_q;
  assign BUSY_O   = busy_q;

endmodule

// File: tb/tb_wb_bus_controller.sv
// Bench for wb_bus_controller: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_wb_bus_controller;
  localparam int TMO = 16;

  logic         clk, rst;
  logic         m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0]  m0_adr, m0_wd, m1_adr, m1_wd;
  logic [31:0]  m0_rd, m1_rd;
  logic         m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]  s_adr, s_wd;
  logic         s_we, busy;
  logic [3:0]   s_stb, s_ack, extra_ack;
  logic [127:0] s_rd;
  logic [31:0]  ram_val;
  int           ack_k [4];
  int           stb_age [4];
  int           n_checks = 0;
  int           n_fail = 0;

  wb_bus_controller dut (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
    .M0_DAT_I(m0_wd), .M0_DAT_O(m0_rd), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
    .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
    .M1_DAT_I(m1_wd), .M1_DAT_O(m1_rd), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
    .S_ADR_O(s_adr), .S_DAT_O(s_wd), .S_WE_O(s_we), .S_STB_O(s_stb),
    .S_DAT_I(s_rd), .S_ACK_I(s_ack), .BUSY_O(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave n acknowledges in its ack_k-th consecutive strobe cycle (0 = never).
  assign s_rd = {ram_val, 32'h33330003, 32'h22220002, 32'h11110001};
  always @(posedge clk)
    for (int n = 0; n < 4; n++) stb_age[n] <= s_stb[n] ? stb_age[n] + 1 : 0;
  always_comb begin
    s_ack = '0;
    for (int n = 0; n < 4; n++)
      s_ack[n] = (s_stb[n] && ack_k[n] != 0 && stb_age[n] + 1 == ack_k[n]) || extra_ack[n];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] e_adr, e_wd, e_rd0, e_rd1;
  logic        e_we, e_busy, e_ack0, e_err0, e_ack1, e_err1;
  logic [3:0]  e_stb;
  bit          in_txn, answering, last_was_m1, model_valid;
  int          owner, slave, bus_cycles;

  function automatic int slave_of(input logic [31:0] a);
    if (a == 32'hFFFF0000) return 0;
    if (a == 32'hEEEE0000) return 1;
    if (a[31:16] == 16'hAAAA) return 2;
    return 3;
  endfunction

  task automatic model_step();
    bit r0, r1, cyc, ok;
    logic [31:0] d;
    r0 = m0_cyc && m0_stb;
    r1 = m1_cyc && m1_stb;
    e_ack0 = 0; e_err0 = 0; e_ack1 = 0; e_err1 = 0;
    if (rst) begin
      e_adr = 0; e_wd = 0; e_we = 0; e_stb = 0; e_rd0 = 0; e_rd1 = 0;
      in_txn = 0; answering = 0; last_was_m1 = 1; bus_cycles = 0;
    end else if (!in_txn) begin
      if (r0 || r1) begin
        owner = (r0 && r1) ? (last_was_m1 ? 0 : 1) : (r0 ? 0 : 1);
        last_was_m1 = (owner == 1);
        e_adr = owner ? m1_adr : m0_adr;
        e_wd  = owner ? m1_wd : m0_wd;
        e_we  = owner ? m1_we : m0_we;
        slave = slave_of(e_adr);
        e_stb = 4'b0001 << slave;
        in_txn = 1; bus_cycles = 0;
      end
    end else if (answering) begin
      in_txn = 0; answering = 0;
    end else begin
      bus_cycles++;
      cyc = owner ? m1_cyc : m0_cyc;
      ok = s_ack[slave];
      if (!cyc) begin
        in_txn = 0; e_stb = 0;
      end else if (ok || bus_cycles == TMO) begin
        d = (ok && !e_we) ? s_rd[32*slave +: 32] : 32'h0;
        answering = 1; e_stb = 0;
        if (owner == 0) begin e_rd0 = d; e_ack0 = ok; e_err0 = !ok; end
        else            begin e_rd1 = d; e_ack1 = ok; e_err1 = !ok; end
      end
    end
    e_busy = in_txn;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("s_adr", s_adr, e_adr);     chk("s_dat", s_wd, e_wd);
      chk("s_we", s_we, e_we);        chk("s_stb", s_stb, e_stb);
      chk("busy", busy, e_busy);
      chk("m0_ack", m0_ack, e_ack0);  chk("m0_err", m0_err, e_err0);
      chk("m0_dat", m0_rd, e_rd0);
      chk("m1_ack", m1_ack, e_ack1);  chk("m1_err", m1_err, e_err1);
      chk("m1_dat", m1_rd, e_rd1);
    end
    model_step();
    if (rst) model_valid = 1;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic on, input logic [31:0] a, input logic [31:0] d,
                         input logic w);
    if (m == 0) begin m0_cyc = on; m0_stb = on; m0_adr = a; m0_wd = d; m0_we = w; end
    else        begin m1_cyc = on; m1_stb = on; m1_adr = a; m1_wd = d; m1_we = w; end
  endtask

  function automatic logic done_of(input int m);
    return (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
  endfunction

  task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] d, input logic w,
                      output int lat);
    set_req(m, 1, a, d, w);
    lat = 0;
    do begin step(1); lat++; end while (!done_of(m) && lat < 40);
    chk("xfer_done", done_of(m), 1'b1);
    set_req(m, 0, a, d, w);
    step(1);
  endtask

  // Request in IDLE, slave acknowledging on its first strobe cycle.
  task automatic single(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] xs, input logic [31:0] xr);
    set_req(0, 1, a, d, w);
    step(1);
    chk({nm, "_stb"}, s_stb, xs);
    chk({nm, "_we"}, s_we, w);
    chk({nm, "_sdat"}, s_wd, d);
    step(1);
    chk({nm, "_ack"}, m0_ack, 1'b1);
    chk({nm, "_rdat"}, m0_rd, xr);
    set_req(0, 0, a, d, w);
    step(1);
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
    step(1);
  endtask

  int lat, cnt, seen;
  int order [4];

  initial begin
    rst = 1; extra_ack = '0; ram_val = 32'h12345678;
    for (int n = 0; n < 4; n++) ack_k[n] = 1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step(3);
    chk("reset_stb", s_stb, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    rst = 0;
    step(1);

    single("rd_ram", 32'h00000010, 32'h0, 1'b0, 4'b1000, 32'h12345678);
    single("wr_led", 32'hFFFF0000, 32'h0000A5A5, 1'b1, 4'b0001, 32'h0);
    single("wr_seg", 32'hEEEE0000, 32'h00005A5A, 1'b1, 4'b0010, 32'h0);
    single("wr_vga", 32'hAAAA1234, 32'h0000C3C3, 1'b1, 4'b0100, 32'h0);
    single("rd_seg", 32'hEEEE0000, 32'h0, 1'b0, 4'b0010, 32'h22220002);
    single("rd_vgaish", 32'hAAAB0000, 32'h0, 1'b0, 4'b1000, 32'h12345678);

    // unselected-slave ACK must not complete a RAM transfer
    extra_ack = 4'b0101; ack_k[3] = 3;
    xfer(0, 32'h00000040, 32'h0, 1'b0, lat);
    chk("unsel_ack_lat", lat, 4);
    extra_ack = '0; ack_k[3] = 1;

    // simultaneous requests after reset: M0, M1, M0, M1
    do_reset();
    ram_val = 32'hCAFE0001;
    set_req(0, 1, 32'h00000100, 32'h0, 1'b0);
    set_req(1, 1, 32'h00000200, 32'h0, 1'b0);
    seen = 0; cnt = 0;
    while (seen < 4 && cnt < 40) begin
      step(1); cnt++;
      if (m0_ack) begin order[seen] = 0; seen++; end
      else if (m1_ack) begin order[seen] = 1; seen++; end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    chk("arb_count", seen, 4);
    chk("arb_0", order[0], 0); chk("arb_1", order[1], 1);
    chk("arb_2", order[2], 0); chk("arb_3", order[3], 1);
    chk("arb_m1_dat", m1_rd, 32'hCAFE0001);
    step(1);

    // VGA never acknowledges: 16 strobe cycles then ERR with zero data
    ack_k[2] = 0;
    set_req(0, 1, 32'hAAAA1234, 32'h0, 1'b0);
    cnt = 0; lat = 0;
    while (!m0_err && lat < 40) begin
      step(1); lat++;
      if (s_stb == 4'b0100) cnt++;
    end
    chk("tmo_stb_cycles", cnt, TMO);
    chk("tmo_lat", lat, TMO + 1);
    chk("tmo_err", m0_err, 1'b1);
    chk("tmo_dat", m0_rd, 32'h0);
    set_req(0, 0, 0, 0, 0);
    step(1);
    ack_k[2] = 1;

    // M1 abort in its third BUS cycle
    ack_k[3] = 0;
    set_req(1, 1, 32'h00000300, 32'h0, 1'b0);
    step(3);
    chk("abort_stb_before", s_stb, 4'b1000);
    set_req(1, 0, 32'h00000300, 32'h0, 1'b0);
    step(1);
    chk("abort_stb", s_stb, 4'b0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ack", m1_ack | m1_err, 1'b0);
    step(2);

    // ACK and CYC drop in the same cycle: abort wins
    ack_k[3] = 2;
    set_req(0, 1, 32'h00000310, 32'h0, 1'b0);
    step(2);
    set_req(0, 0, 32'h00000310, 32'h0, 1'b0);
    step(1);
    chk("ackabort_ack", m0_ack | m0_err, 1'b0);
    chk("ackabort_busy", busy, 1'b0);
    step(2);

    // reset during BUS, then a normal transfer
    ack_k[3] = 0;
    set_req(0, 1, 32'h00000050, 32'h00000077, 1'b1);
    step(2);
    rst = 1;
    set_req(0, 0, 0, 0, 0);
    step(1);
    chk("rst_stb", s_stb, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_adr", s_adr, 32'h0);
    chk("rst_m0dat", m0_rd, 32'h0);
    rst = 0;
    ack_k[3] = 1;
    ram_val = 32'h0BADF00D;
    step(1);
    xfer(0, 32'h00000060, 32'h0, 1'b0, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_dat", m0_rd, 32'h0BADF00D);

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
